// File: rtl/dcache_responder.sv
// Direct-mapped, write-back L1 data cache for the MEM-stage data port.
// It serves 32-bit word accesses from the core and fills/evicts 256-bit lines from physical memory.
module dcache_responder #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

    state_t r_state, w_next;

    logic [31:2]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_write;
    logic [31:0]        r_rdata;
    logic [SETS-1:0]    r_valid;
    logic [SETS-1:0]    r_dirty;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [255:0]       r_line [SETS];

    logic [TAG_W-1:0]   w_tag;
    logic [S_INDEX-1:0] w_index;
    logic [2:0]         w_word;
    logic [255:0]       w_line;
    logic [31:0]        w_word_data;
    logic [31:0]        w_merged;
    logic               w_hit;
    logic               w_req;
    logic               w_unused;

    // Byte offset bits never reach the cache; only word-aligned accesses exist.
    assign w_unused    = ^mem_address[1:0];

    assign w_req       = mem_read | mem_write;
    assign w_tag       = r_addr[31:5+S_INDEX];
    assign w_index     = r_addr[4+S_INDEX:5];
    assign w_word      = r_addr[4:2];
    assign w_line      = r_line[w_index];
    assign w_word_data = w_line[{w_word, 5'b0} +: 32];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_comb begin
        w_merged = w_word_data;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) w_merged[i*8 +: 8] = r_wdata[i*8 +: 8];
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                CHECK: begin
                    if (w_hit && r_write)  r_dirty[w_index] <= 1'b1;
                    if (w_hit && !r_write) r_rdata <= w_word_data;
                end
                WRITEBACK: if (pmem_resp) r_dirty[w_index] <= 1'b0;
                FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/line storage and the request latch carry no reset; valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_req) begin
            r_addr  <= mem_address[31:2];
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
            r_write <= mem_write;
        end
        if (r_state == CHECK && w_hit && r_write)
            r_line[w_index][{w_word, 5'b0} +: 32] <= w_merged;
        if (r_state == FILL && pmem_resp) begin
            r_line[w_index] <= pmem_rdata;
            r_tag[w_index]  <= w_tag;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        w_next       = r_state;
        mem_resp     = 1'b0;
        mem_rdata    = r_rdata;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            IDLE: if (w_req) w_next = CHECK;
            CHECK: begin
                if (w_hit) begin
                    mem_resp = 1'b1;
                    // Load data is forwarded in the response cycle and held in r_rdata afterwards.
                    if (!r_write) mem_rdata = w_word_data;
                    w_next = IDLE;
                end else if (r_valid[w_index] && r_dirty[w_index]) begin
                    w_next = WRITEBACK;
                end else begin
                    w_next = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_index], w_index, 5'b0};
                pmem_wdata   = w_line;
                if (pmem_resp) w_next = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_index, 5'b0};
                if (pmem_resp) w_next = CHECK;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: a flat byte-level memory model predicts core-visible data,
// a per-set tag directory predicts fills/writebacks, and a random-latency memory answers line requests.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    dcache_responder #(.S_INDEX(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } pev_t;

    pev_t         plog[$];
    logic [255:0] pmem_mem [logic [31:0]];
    logic [31:0]  ref_mem  [logic [31:0]];
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [23:0]  m_tag   [8];
    logic [31:0]  last_rdata;
    int total = 0;
    int bad = 0;
    int resp_pulses = 0;
    int strobe_viol = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [255:0] backing_line(input logic [31:0] la);
        logic [255:0] l;
        if (pmem_mem.exists(la)) return pmem_mem[la];
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(la + 32'(k * 4));
        return l;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  key;
        key = {a[31:2], 2'b00};
        if (ref_mem.exists(key)) return ref_mem[key];
        l = backing_line({a[31:5], 5'b0});
        return l[a[4:2]*32 +: 32];
    endfunction

    // Physical memory: answers each strobe after 1-4 cycles and logs the traffic.
    initial begin
        int lat, cnt;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        lat = $urandom_range(1, 4);
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (rst && (pmem_read || pmem_write)) begin
                cnt++;
                if (cnt >= lat) begin
                    if (pmem_write) begin
                        pmem_mem[pmem_address] = pmem_wdata;
                        plog.push_back('{1'b1, pmem_address, pmem_wdata});
                    end else begin
                        pmem_rdata = backing_line(pmem_address);
                        plog.push_back('{1'b0, pmem_address, pmem_rdata});
                    end
                    pmem_resp = 1'b1;
                    cnt = 0;
                    lat = $urandom_range(1, 4);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_resp) resp_pulses++;
        if (pmem_read && pmem_write) strobe_viol++;
        assert (!(mem_read && mem_write)) else $error("core asserted read and write together");
    end

    task automatic reset_dut();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ref_mem.delete();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        last_rdata = '0;
    endtask

    // One core access; must be entered just after a rising edge.
    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] obs_rdata, output int obs_cyc);
        logic [2:0]   set;
        logic [23:0]  tag;
        logic [31:0]  exp_rd, old_la, merged;
        logic [255:0] exp_line;
        bit           hit, exp_wb, got;
        int           nrd, nwr, cyc;
        set    = a[7:5];
        tag    = a[31:8];
        hit    = m_valid[set] && (m_tag[set] == tag);
        exp_wb = !hit && m_valid[set] && m_dirty[set];
        old_la = {m_tag[set], set, 5'b0};
        exp_line = '0;
        if (exp_wb) for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = ref_read(old_la + 32'(k * 4));
        exp_rd = ref_read(a);
        plog.delete();
        mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata = wd; mem_byte_enable = be;
        cyc = 0; got = 1'b0; obs_rdata = 'x;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                got = 1'b1;
                obs_rdata = mem_rdata;
            end
        end
        obs_cyc = cyc;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL resp_timeout addr=%h: no mem_resp within %0d cycles", a, cyc);
        end else begin
            total++;
            if (obs_rdata !== (wr ? last_rdata : exp_rd)) begin
                bad++;
                $display("FAIL rdata addr=%h wr=%0b: got %h expected %h", a, wr, obs_rdata, wr ? last_rdata : exp_rd);
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        nrd = 0; nwr = 0;
        foreach (plog[i]) if (plog[i].wr) nwr++; else nrd++;
        total++;
        if (nwr !== int'(exp_wb)) begin
            bad++;
            $display("FAIL writeback_count addr=%h: got %0d expected %0d", a, nwr, exp_wb);
        end
        total++;
        if (nrd !== int'(!hit)) begin
            bad++;
            $display("FAIL fill_count addr=%h: got %0d expected %0d", a, nrd, !hit);
        end
        if (hit) begin
            total++;
            if (cyc !== 2) begin
                bad++;
                $display("FAIL hit_latency addr=%h: got %0d expected 2", a, cyc);
            end
        end
        if (exp_wb && nwr == 1 && plog.size() > 0 && plog[0].wr) begin
            total++;
            if (plog[0].addr !== old_la || plog[0].data !== exp_line) begin
                bad++;
                $display("FAIL writeback addr=%h: got %h/%h expected %h/%h", a, plog[0].addr, plog[0].data[63:0], old_la, exp_line[63:0]);
            end
        end
        if (!hit && nrd == 1) begin
            total++;
            if (plog[plog.size()-1].wr || plog[plog.size()-1].addr !== {a[31:5], 5'b0}) begin
                bad++;
                $display("FAIL fill_addr addr=%h: got %h (last op wr=%0b) expected %h", a, plog[plog.size()-1].addr, plog[plog.size()-1].wr, {a[31:5], 5'b0});
            end
        end
        if (wr) begin
            merged = exp_rd;
            for (int i = 0; i < 4; i++) if (be[i]) merged[i*8 +: 8] = wd[i*8 +: 8];
            ref_mem[{a[31:2], 2'b00}] = merged;
        end else begin
            last_rdata = exp_rd;
        end
        m_dirty[set] = hit ? (m_dirty[set] | wr) : wr;
        m_valid[set] = 1'b1;
        m_tag[set]   = tag;
    endtask

    task automatic test_reset();
        logic [255:0] l;
        logic [31:0]  rd;
        int           cyc;
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mem_resp !== 1'b0)   begin bad++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); end
        total++; if (pmem_read !== 1'b0)  begin bad++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
        total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL reset_pmem_write: got %b expected 0", pmem_write); end
        total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
        total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL reset_pmem_address: got %h expected 0", pmem_address); end
        total++; if (pmem_wdata !== 256'h0) begin bad++; $display("FAIL reset_pmem_wdata: got %h expected 0", pmem_wdata[63:0]); end
        rst = 1'b1;
        for (int s = 0; s < 8; s++) begin m_valid[s] = 1'b0; m_dirty[s] = 1'b0; end
        last_rdata = '0;
        l = backing_line(32'h60);
        l[63:32] = 32'hDEADBEEF;
        pmem_mem[32'h60] = l;
        do_access(1'b0, 32'h64, '0, '0, rd, cyc);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL clean_miss_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_hit();
        logic [31:0] rd;
        int          cyc;
        do_access(1'b0, 32'h64, '0, '0, rd, cyc);
        total++;
        if (cyc !== 2 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL repeat_hit: got %0d cycles/%h expected 2/deadbeef", cyc, rd);
        end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd;
        int          cyc;
        do_access(1'b1, 32'h64, 32'h11223344, 4'b0110, rd, cyc);
        do_access(1'b0, 32'h64, '0, '0, rd, cyc);
        total++;
        if (rd !== 32'hDE2233EF) begin bad++; $display("FAIL partial_write: got %h expected de2233ef", rd); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] rd;
        int          cyc;
        do_access(1'b0, 32'h164, '0, '0, rd, cyc);
        total++;
        if (plog.size() != 2 || !plog[0].wr || plog[0].addr !== 32'h60 || plog[0].data[63:32] !== 32'hDE2233EF
            || plog[1].wr || plog[1].addr !== 32'h160) begin
            bad++;
            $display("FAIL dirty_evict: got %0d events, first addr %h word1 %h expected wr 00000060/de2233ef then rd 00000160",
                     plog.size(), plog.size() > 0 ? plog[0].addr : 32'h0, plog.size() > 0 ? plog[0].data[63:32] : 32'h0);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd;
        int          cyc;
        bit          seen;
        mem_read = 1'b1; mem_address = 32'h2A4;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_fill_start: pmem_read got 0 expected 1"); end
        rst = 1'b0;
        #1;
        total++;
        if (pmem_read !== 1'b0) begin bad++; $display("FAIL mid_fill_drop: pmem_read got %b expected 0", pmem_read); end
        mem_read = 1'b0;
        reset_dut();
        plog.delete();
        do_access(1'b0, 32'h2A4, '0, '0, rd, cyc);
        total++;
        if (cyc <= 2) begin bad++; $display("FAIL mid_fill_remiss: got %0d cycles expected more than 2", cyc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          cyc, start;
        do_access(1'b0, 32'h1E0, '0, '0, rd, cyc);
        start = resp_pulses;
        for (int i = 0; i < 8; i++) begin
            do_access(i[0], 32'h1E0 + 32'(($urandom_range(0, 7)) * 4), $urandom, 4'($urandom), rd, cyc);
        end
        total++;
        if (resp_pulses - start !== 8) begin
            bad++;
            $display("FAIL back_to_back_resp_count: got %0d expected 8", resp_pulses - start);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a;
        int          cyc;
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            do_access($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), rd, cyc);
        end
        total++;
        if (strobe_viol !== 0) begin bad++; $display("FAIL strobe_overlap: got %0d cycles expected 0", strobe_viol); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_partial_write();
        test_dirty_evict();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
